// File: rtl/mdu_multicycle_pkg.sv
// Shared constants for the multiply/divide unit: operation encodings, FSM
// state codes and the multi-cycle decode helper.
// The decoder, the hazard unit and the MDU itself import this package.
// Optional feature macro: MDU_MADD_EN. When it is defined, MADD/MADDU/MSUB/MSUBU
// count as multi-cycle ops. When it is undefined, they decode as NONE.
package mdu_multicycle_pkg;

  localparam int unsigned MDU_OP_W = 4;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // True for codes that occupy the unit for several cycles and must stall.
  function automatic logic mdu_is_multi(input logic [MDU_OP_W-1:0] op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_multicycle_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
//   start, mdu_op, inputA, inputB : issue side, driven by EX (master)
//   busy, stall_req               : hazard-unit feedback, driven by the MDU (slave)
//   hi_out, lo_out                : architectural HI/LO for MFHI/MFLO
interface mdu_multicycle_if #(
  parameter int unsigned WIDTH = 32
);
  import mdu_multicycle_pkg::*;

  logic                start;
  logic [MDU_OP_W-1:0] mdu_op;
  logic [WIDTH-1:0]    inputA;
  logic [WIDTH-1:0]    inputB;
  logic                busy;
  logic                stall_req;
  logic [WIDTH-1:0]    hi_out;
  logic [WIDTH-1:0]    lo_out;

  modport master (
    output start, mdu_op, inputA, inputB,
    input  busy, stall_req, hi_out, lo_out
  );

  modport slave (
    input  start, mdu_op, inputA, inputB,
    output busy, stall_req, hi_out, lo_out
  );

endinterface

// File: rtl/mdu_cycle_counter.sv
// Loadable down-counter that times one MDU operation.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_value this edge (takes priority over counting)
//   load_value : number of busy cycles for the operation being issued
//   enable     : count down (high while the operation runs)
//   done_c     : combinational; high in the cycle whose edge brings the count to 0
module mdu_cycle_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             done_c
);

  logic [CNT_W-1:0] count_q;

  // Down-counter that saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign done_c = enable && (count_q == CNT_W'(1));

endmodule

// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// The result is computed when the operation is issued and held in a pending
// register. It is committed to HI/LO after MULT_CYCLES or DIV_CYCLES busy cycles.
//   clk, reset : clock, synchronous active-high reset
//   bus.start  : one-cycle issue strobe; ignored while busy
//   bus.mdu_op : operation code (mdu_op_e); unknown codes do nothing
//   bus.inputA : rs operand; bus.inputB : rt operand
//   bus.busy   : registered; high for exactly N cycles after an accepted start
//   bus.stall_req : combinational; busy, or a multi-cycle op being issued
//   bus.hi_out, bus.lo_out : current HI/LO
// Optional feature macro: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU.
module mdu_multicycle
  import mdu_multicycle_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  mdu_multicycle_if.slave bus
);

  localparam int unsigned DW         = 2 * WIDTH;
  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] pend_hi_q;
  logic [WIDTH-1:0] pend_lo_q;
  logic             pend_wr_q;

  logic             op_multi_c;
  logic             op_div_c;
  logic             op_signed_c;
`ifdef MDU_MADD_EN
  logic             op_acc_c;
  logic             op_sub_c;
`endif

  logic [DW-1:0]    mul_a_c;
  logic [DW-1:0]    mul_b_c;
  logic [DW-1:0]    prod_c;
  logic             a_neg_c;
  logic             b_neg_c;
  logic             div_zero_c;
  logic [WIDTH-1:0] dvd_c;
  logic [WIDTH-1:0] dvs_c;
  logic [WIDTH-1:0] quo_mag_c;
  logic [WIDTH-1:0] rem_mag_c;
  logic [WIDTH-1:0] quo_c;
  logic [WIDTH-1:0] rem_c;
  logic [DW-1:0]    result_c;

  logic             cnt_load_c;
  logic [CNT_W-1:0] cnt_value_c;
  logic             cnt_done_c;

  // Operation decode: datapath selects for the op presented this cycle.
  always_comb begin : decode
    op_multi_c  = mdu_is_multi(bus.mdu_op);
    op_div_c    = 1'b0;
    op_signed_c = 1'b0;
`ifdef MDU_MADD_EN
    op_acc_c    = 1'b0;
    op_sub_c    = 1'b0;
`endif
    case (bus.mdu_op)
      MDU_MULT:  op_signed_c = 1'b1;
      MDU_DIV:   begin op_div_c = 1'b1; op_signed_c = 1'b1; end
      MDU_DIVU:  op_div_c = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD:  begin op_acc_c = 1'b1; op_signed_c = 1'b1; end
      MDU_MADDU: op_acc_c = 1'b1;
      MDU_MSUB:  begin op_acc_c = 1'b1; op_sub_c = 1'b1; op_signed_c = 1'b1; end
      MDU_MSUBU: begin op_acc_c = 1'b1; op_sub_c = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Issue-time arithmetic. There is one multiplier for both signed and unsigned
  // ops: operands are extended to 2*WIDTH and the low half of the product is
  // kept. Division runs on magnitudes, and the signs are restored afterwards.
  // This makes INT_MIN / -1 come out as quotient INT_MIN, remainder 0, with no
  // special case.
  always_comb begin : datapath
    mul_a_c = op_signed_c ? {{WIDTH{bus.inputA[WIDTH-1]}}, bus.inputA}
                          : {{WIDTH{1'b0}}, bus.inputA};
    mul_b_c = op_signed_c ? {{WIDTH{bus.inputB[WIDTH-1]}}, bus.inputB}
                          : {{WIDTH{1'b0}}, bus.inputB};
    prod_c  = mul_a_c * mul_b_c;

    a_neg_c    = op_signed_c & bus.inputA[WIDTH-1];
    b_neg_c    = op_signed_c & bus.inputB[WIDTH-1];
    div_zero_c = (bus.inputB == '0);
    dvd_c      = a_neg_c ? (WIDTH'(0) - bus.inputA) : bus.inputA;
    // A zero divisor is replaced by 1 so the divider stays defined; the result is discarded.
    dvs_c      = div_zero_c ? WIDTH'(1)
                            : (b_neg_c ? (WIDTH'(0) - bus.inputB) : bus.inputB);
    quo_mag_c  = dvd_c / dvs_c;
    rem_mag_c  = dvd_c % dvs_c;
    quo_c      = (a_neg_c ^ b_neg_c) ? (WIDTH'(0) - quo_mag_c) : quo_mag_c;
    rem_c      = a_neg_c ? (WIDTH'(0) - rem_mag_c) : rem_mag_c;

    result_c = op_div_c ? {rem_c, quo_c} : prod_c;
`ifdef MDU_MADD_EN
    if (op_acc_c) begin
      result_c = op_sub_c ? ({hi_q, lo_q} - prod_c) : ({hi_q, lo_q} + prod_c);
    end
`endif
  end

  // Busy-cycle timer.
  assign cnt_load_c  = (state_q == ST_IDLE) && bus.start && op_multi_c;
  assign cnt_value_c = op_div_c ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  mdu_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load_c),
    .load_value (cnt_value_c),
    .enable     (state_q == ST_RUN),
    .done_c     (cnt_done_c)
  );

  // Control FSM and HI/LO ownership. Issue is only accepted in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (op_multi_c) begin
              pend_hi_q <= result_c[DW-1:WIDTH];
              pend_lo_q <= result_c[WIDTH-1:0];
              pend_wr_q <= !(op_div_c && div_zero_c);
              state_q   <= ST_RUN;
              busy_q    <= 1'b1;
            end else if (bus.mdu_op == MDU_MTHI) begin
              hi_q <= bus.inputA;
            end else if (bus.mdu_op == MDU_MTLO) begin
              lo_q <= bus.inputA;
            end
          end
        end
        ST_RUN: begin
          if (cnt_done_c) begin
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  // The issue cycle raises the stall too, so an MFLO right behind a MULT waits.
  assign bus.stall_req = busy_q | (bus.start & op_multi_c);
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;

endmodule

// File: tb/tb_mdu_multicycle.sv
// Self-checking bench for mdu_multicycle: directed cases plus randomized
// issue streams. The expected results are queued at issue, and a monitor
// pops one entry each time busy falls.
module tb_mdu_multicycle;
  import mdu_multicycle_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned NM = 5;
  localparam int unsigned ND = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_multicycle_if #(.WIDTH(W)) bus ();

  mdu_multicycle #(
    .WIDTH       (W),
    .MULT_CYCLES (NM),
    .DIV_CYCLES  (ND)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cycles;
    int           op;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Architectural model: visible HI/LO, remaining busy cycles, pending commit.
  logic [W-1:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
  logic         m_pend_wr;
  int           m_cnt   = 0;
  bit           m_known = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic bit is_multi(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10};
`else
    return op inside {4'd1, 4'd2, 4'd3, 4'd4};
`endif
  endfunction

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Apply the effect of one rising edge to the model, using the inputs now driven.
  task automatic model_edge();
    longint       sa, sb;
    logic [63:0]  ua, ub, acc, r;
    exp_t         e;
    if (rst) begin
      m_hi = '0; m_lo = '0; m_cnt = 0; m_known = 1'b1;
      exp_q.delete();
      return;
    end
    if (!m_known) return;
    if (m_cnt != 0) begin
      m_cnt--;
      if (m_cnt == 0 && m_pend_wr) begin
        m_hi = m_pend_hi;
        m_lo = m_pend_lo;
      end
      return;
    end
    if (!bus.start) return;
    sa  = $signed(bus.inputA);
    sb  = $signed(bus.inputB);
    ua  = {32'h0, bus.inputA};
    ub  = {32'h0, bus.inputB};
    acc = {m_hi, m_lo};
    r   = '0;
    m_pend_wr = 1'b1;
    e.cycles  = NM;
    case (bus.mdu_op)
      MDU_MULT:  r = 64'(sa * sb);
      MDU_MULTU: r = ua * ub;
      MDU_DIV: begin
        e.cycles = ND;
        if (sb == 0) m_pend_wr = 1'b0;
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      MDU_DIVU: begin
        e.cycles = ND;
        if (ub == 0) m_pend_wr = 1'b0;
        else r = {32'(ua % ub), 32'(ua / ub)};
      end
      MDU_MTHI: begin m_hi = bus.inputA; return; end
      MDU_MTLO: begin m_lo = bus.inputA; return; end
`ifdef MDU_MADD_EN
      MDU_MADD:  r = acc + 64'(sa * sb);
      MDU_MADDU: r = acc + ua * ub;
      MDU_MSUB:  r = acc - 64'(sa * sb);
      MDU_MSUBU: r = acc - ua * ub;
`endif
      default: return;
    endcase
    m_pend_hi = r[63:32];
    m_pend_lo = r[31:0];
    e.hi  = m_pend_wr ? r[63:32] : m_hi;
    e.lo  = m_pend_wr ? r[31:0]  : m_lo;
    e.op  = int'(bus.mdu_op);
    exp_q.push_back(e);
    m_cnt = e.cycles;
  endtask

  // One clock: check the visible state mid-cycle, then advance the model at the edge.
  task automatic cycle();
    @(negedge clk);
    if (m_known) begin
      chk("busy", 64'(bus.busy), 64'(m_cnt != 0));
      chk("stall_req", 64'(bus.stall_req),
          64'((m_cnt != 0) || (bus.start && is_multi(bus.mdu_op))));
      chk("hi_out", 64'(bus.hi_out), 64'(m_hi));
      chk("lo_out", 64'(bus.lo_out), 64'(m_lo));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.inputA = a;
    bus.inputB = b;
    cycle();
    bus.start  = 1'b0;
    bus.mdu_op = 4'(MDU_NONE);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_cnt != 0 && k < 64) begin
      cycle();
      k++;
    end
    cycle();
  endtask

  task automatic expect_hilo(input string name, input logic [W-1:0] hi, input logic [W-1:0] lo);
    chk({name, "_hi"}, 64'(bus.hi_out), 64'(hi));
    chk({name, "_lo"}, 64'(bus.lo_out), 64'(lo));
  endtask

  // Monitor: each falling edge of busy outside reset must match the oldest queued result.
  initial begin : monitor
    int   run  = 0;
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst || !m_known) begin
        run  = 0;
        prev = 1'b0;
      end else begin
        if (bus.busy === 1'b1) begin
          run++;
        end else if (prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_commit", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("commit_hi op=%0d", e.op), 64'(bus.hi_out), 64'(e.hi));
            chk($sformatf("commit_lo op=%0d", e.op), 64'(bus.lo_out), 64'(e.lo));
            chk($sformatf("busy_cycles op=%0d", e.op), 64'(run), 64'(e.cycles));
          end
          run = 0;
        end
        prev = bus.busy;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.mdu_op = 4'(MDU_NONE);
    bus.inputA = '0;
    bus.inputB = '0;
    idle(3);
    chk("reset_busy", 64'(bus.busy), 64'(0));
    expect_hilo("reset", 32'h0, 32'h0);
    rst = 1'b0;

    // Reset in the middle of a MULT discards the pending 12.
    issue(4'(MDU_MULT), 32'd3, 32'd4);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_mid_busy", 64'(bus.busy), 64'(0));
    expect_hilo("rst_mid", 32'h0, 32'h0);
    idle(8);
    expect_hilo("rst_mid_later", 32'h0, 32'h0);

    issue(4'(MDU_MULT), 32'hFFFF_FFFF, 32'h2);
    wait_idle();
    expect_hilo("mult_neg1x2", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(4'(MDU_MULTU), 32'hFFFF_FFFF, 32'h2);
    wait_idle();
    expect_hilo("multu_max_x2", 32'h0000_0001, 32'hFFFF_FFFE);
    issue(4'(MDU_DIV), 32'hFFFF_FFF9, 32'h2);
    wait_idle();
    expect_hilo("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(4'(MDU_DIV), 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    expect_hilo("div_intmin_m1", 32'h0, 32'h8000_0000);

    issue(4'(MDU_MTHI), 32'h1234, 32'h0);
    cycle();
    chk("mthi", 64'(bus.hi_out), 64'(32'h1234));
    issue(4'(MDU_DIVU), 32'd5, 32'd0);
    wait_idle();
    expect_hilo("divu_by_zero", 32'h1234, 32'h8000_0000);

    // Issue attempts during busy are ignored; only the DIV result lands.
    issue(4'(MDU_DIV), 32'd100, 32'd7);
    idle(2);
    issue(4'(MDU_MULT), 32'd5, 32'd6);
    issue(4'(MDU_MTLO), 32'hDEAD, 32'h0);
    wait_idle();
    expect_hilo("start_while_busy", 32'd2, 32'd14);

`ifdef MDU_MADD_EN
    issue(4'(MDU_MTHI), 32'h0, 32'h0);
    issue(4'(MDU_MTLO), 32'd10, 32'h0);
    issue(4'(MDU_MADD), 32'd3, 32'd4);
    wait_idle();
    expect_hilo("madd", 32'h0, 32'd22);
    issue(4'(MDU_MSUBU), 32'd1, 32'd23);
    wait_idle();
    expect_hilo("msubu", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`endif

    // Random stream: random ops and operands, gaps that may hit busy, rare resets.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end
      issue(4'($urandom_range(0, 15)), rnd(), rnd());
      n = $urandom_range(0, 12);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 5) == 0) issue(4'($urandom_range(0, 15)), rnd(), rnd());
        else cycle();
      end
    end
    wait_idle();
    idle(2);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
